// File: rtl/seq_divider_8b.sv
// Sequential 8-bit by 4-bit restoring divider with one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN finishes a divide-by-zero after a single RUN cycle.
module seq_divider_8b (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] x,
    input  logic [3:0] y,
    output logic       busy,
    output logic       done,
    output logic [7:0] q,
    output logic [3:0] r,
    output logic       dz
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [7:0] dvd;
    logic [3:0] dsr;
    logic [4:0] rem;
    logic [2:0] cnt;

    logic [5:0] rem_sh;
    logic [4:0] rem_nx;
    logic [7:0] dvd_nx;
    logic       qbit;
    logic       fast_zero;

    // One restoring step; quotient bits fill the dividend register from the right.
    always_comb begin
        rem_sh = {rem, dvd[7]};
        qbit   = (rem_sh >= {2'b00, dsr});
        rem_nx = qbit ? (rem_sh[4:0] - {1'b0, dsr}) : rem_sh[4:0];
        dvd_nx = {dvd[6:0], qbit};
`ifdef DIV_ZERO_FAST_EN
        fast_zero = (dsr == 4'd0);
`else
        fast_zero = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (fast_zero || cnt == 3'd7) state_n = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd <= 8'd0;
            dsr <= 4'd0;
            rem <= 5'd0;
            cnt <= 3'd0;
            q   <= 8'd0;
            r   <= 4'd0;
            dz  <= 1'b0;
        end else if (state == IDLE && start) begin
            dvd <= x;
            dsr <= y;
            rem <= 5'd0;
            cnt <= 3'd0;
        end else if (state == RUN) begin
            if (fast_zero) begin
                q  <= 8'hFF;
                r  <= dvd[3:0];
                dz <= 1'b1;
            end else begin
                dvd <= dvd_nx;
                rem <= rem_nx;
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    q  <= dvd_nx;
                    r  <= rem_nx[3:0];
                    dz <= (dsr == 4'd0);
                end
            end
        end
    end

endmodule

// File: doc/seq_divider_8b.md
SEQ_DIVIDER_8B -- requirements
Module: seq_divider_8b

Interface
REQ-001 clk  input  1  clock; all state changes on the rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  request a division; sampled only in IDLE.
REQ-004 x  input  8  unsigned dividend; captured on the accepting edge.
REQ-005 y  input  4  unsigned divisor; captured on the accepting edge.
REQ-006 busy  output  1  high while an accepted operation is in progress (RUN or DONE).
REQ-007 done  output  1  one-cycle pulse marking that q, r and dz are valid for the new result.
REQ-008 q  output  8  unsigned quotient.
REQ-009 r  output  4  unsigned remainder.
REQ-010 dz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-011 The block SHALL be the sequential inverse of the team's 4x4 array multiplier: for y != 0, x == q*y + r with r < y.
REQ-012 The FSM SHALL have three states, IDLE, RUN and DONE. Transitions: IDLE->RUN on start=1; RUN->DONE after 8 iterations; DONE->IDLE unconditionally after one cycle.
REQ-013 On the accepting edge, the block SHALL load x into a shift register, y into a divisor register, clear the 5-bit partial remainder, and set the iteration counter to 0.
REQ-014 Each RUN edge SHALL execute one restoring step:
- shift the partial remainder left, bringing in the dividend MSB;
- if partial remainder >= {1'b0,y}, subtract and shift in quotient bit 1; otherwise shift in quotient bit 0.
REQ-015 The iteration counter SHALL be 3 bits and SHALL wrap from 7 to 0. The eighth step (counter = 7) SHALL move the FSM to DONE.
REQ-016 q, r and dz SHALL update only on the edge that enters DONE, and SHALL hold until the next completion or reset.
REQ-017 done SHALL be 1 exactly during the DONE cycle. With the accepting edge as edge N, done is high in the cycle after edge N+8.
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-019 start SHALL be ignored in RUN and DONE. Changes to x and y after acceptance SHALL have no effect.
REQ-020 When y = 0, the result SHALL be q = 8'hFF, r = x[3:0], dz = 1. This is the natural result of the restoring steps.
REQ-021 When y != 0, dz SHALL be 0.
REQ-022 start held high continuously SHALL start a new operation on the first IDLE edge after each DONE.

Reset
REQ-023 While rst = 1, the block SHALL force the state to IDLE and the outputs to busy=0, done=0, q=0, r=0, dz=0, independent of clk.
REQ-024 An assertion of rst during RUN or DONE SHALL abort the operation with no done pulse. On release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-025 Macro DIV_ZERO_FAST_EN:
- Defined: an accepting edge with y = 0 SHALL go directly to DONE, so done is high in the cycle after edge N+1, with q=8'hFF, r=x[3:0], dz=1.
- Undefined: y = 0 SHALL run the full 8 iterations with the REQ-017 timing.
REQ-026 Results for y != 0 SHALL be identical with and without DIV_ZERO_FAST_EN.

Verification
REQ-027 x=200, y=7 -> done in the cycle after edge N+8; q=28, r=4, dz=0.
REQ-028 x=255, y=15 -> q=17, r=0. Also x=255, y=1 -> q=255, r=0.
REQ-029 x=5, y=9 -> q=0, r=5, dz=0.
REQ-030 x=100, y=0 -> q=8'hFF, r=4, dz=1. Timing: cycle after edge N+8 without DIV_ZERO_FAST_EN, cycle after edge N+1 with it.
REQ-031 Timing scenario: pulse start, change x and y and pulse start again at edges N+3 and N+4, then assert rst at edge N+5 -> busy=0 and q=r=0 immediately, no done pulse. A following start with x=9, y=2 -> q=4, r=1.
REQ-032 Exhaustive sweep of all 4096 (x, y) pairs against the reference model with start tied high -> q, r, dz correct for every pair, with exactly one done pulse per operation.
